// File: rtl/pulp_pwr_pkg.sv
// Shared types and constants for the level-shifter clamp controller.
// Holds the FSM state encoding, lower bounds on timing parameters and sizing helpers.
package pulp_pwr_pkg;

  typedef enum logic [2:0] {
    StOff,
    StWaitPg,
    StRelease,
    StActive,
    StClamping
  } pwr_state_e;

  localparam int unsigned SettleCyclesMin   = 1;
  localparam int unsigned PgFilterCyclesMin = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulp_level_shifter_clamp_ctrl_if.sv
// Domain-crossing bundle between a switchable power domain and the always-on side.
// The slave modport is the controller's view; master is the environment's view.
interface pulp_level_shifter_clamp_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             pwr_req_i;
  logic             pwr_ack_o;
  logic             pwr_good_i;
  logic             clamp_o;
  logic             fault_o;

  modport slave (
    input  data_i,
    input  pwr_req_i,
    input  pwr_good_i,
    output data_o,
    output pwr_ack_o,
    output clamp_o,
    output fault_o
  );

  modport master (
    output data_i,
    output pwr_req_i,
    output pwr_good_i,
    input  data_o,
    input  pwr_ack_o,
    input  clamp_o,
    input  fault_o
  );

endinterface

// File: rtl/pulp_pwr_delay_cnt.sv
// Saturating up-counter used for power-good filtering and clamp settle timing.
// done_o is asserted on the cycle whose enabled sample brings the count to target_i.
module pulp_pwr_delay_cnt
  import pulp_pwr_pkg::*;
#(
  parameter int unsigned MaxCount = 4,
  localparam int unsigned CntW    = cnt_width(MaxCount)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [CntW-1:0] target_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [CntW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != target_i)) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Look-ahead so the FSM can leave its state on the very edge that completes the count.
  assign done_o = (cnt_q == target_i) || (enable_i && (cnt_inc == target_i));

endmodule

// File: rtl/pulp_level_shifter_clamp_ctrl.sv
// Power-domain isolation controller: sequences level-shifter clamps around supply switching
// and substitutes constant/held values on data_o whenever the domain is not fully active.
module pulp_level_shifter_clamp_ctrl
  import pulp_pwr_pkg::*;
#(
  parameter int unsigned      WIDTH            = 32,
  parameter logic [WIDTH-1:0] CLAMP_VAL        = '0,
  parameter logic [WIDTH-1:0] HOLD_MASK        = '0,
  parameter int unsigned      SETTLE_CYCLES    = 4,
  parameter int unsigned      PG_FILTER_CYCLES = 8
) (
  input logic                            clk_i,
  input logic                            rst_ni,
  pulp_level_shifter_clamp_ctrl_if.slave pwr_if
);

  localparam int unsigned SettleTgt = max_u(SETTLE_CYCLES, SettleCyclesMin);
  localparam int unsigned FilterTgt = max_u(PG_FILTER_CYCLES, PgFilterCyclesMin);
  localparam int unsigned SettleW   = cnt_width(SettleTgt);
  localparam int unsigned FilterW   = cnt_width(FilterTgt);

  pwr_state_e       state_q;
  logic             clamp_q;
  logic             ack_q;
  logic             fault_q;
  logic [WIDTH-1:0] hold_q;

  logic in_wait;
  logic release_abort;
  logic filt_en;
  logic filt_clr;
  logic filt_done;
  logic settle_en;
  logic settle_clr;
  logic settle_done;

  // Counters are cleared whenever their owning state is left, so every entry starts at zero.
  always_comb begin
    in_wait       = (state_q == StWaitPg);
    release_abort = (state_q == StRelease) && (!pwr_if.pwr_req_i || !pwr_if.pwr_good_i);
    filt_en       = in_wait && pwr_if.pwr_good_i;
    filt_clr      = !in_wait || !pwr_if.pwr_good_i || !pwr_if.pwr_req_i || filt_done;
    settle_en     = (state_q == StRelease) || (state_q == StClamping);
    settle_clr    = !settle_en || release_abort || settle_done;
  end

  pulp_pwr_delay_cnt #(
    .MaxCount (FilterTgt)
  ) u_filter_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (filt_clr),
    .enable_i (filt_en),
    .target_i (FilterW'(FilterTgt)),
    .done_o   (filt_done)
  );

  pulp_pwr_delay_cnt #(
    .MaxCount (SettleTgt)
  ) u_settle_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (settle_clr),
    .enable_i (settle_en),
    .target_i (SettleW'(SettleTgt)),
    .done_o   (settle_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StOff;
      clamp_q <= 1'b1;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      unique case (state_q)
        StOff: begin
          if (pwr_if.pwr_req_i) begin
            state_q <= StWaitPg;
          end
        end
        StWaitPg: begin
          if (!pwr_if.pwr_req_i) begin
            state_q <= StOff;
          end else if (filt_done) begin
            state_q <= StRelease;
            clamp_q <= 1'b0;
          end
        end
        StRelease: begin
          if (release_abort) begin
            state_q <= StClamping;
            clamp_q <= 1'b1;
          end else if (settle_done) begin
            state_q <= StActive;
            ack_q   <= 1'b1;
          end
        end
        StActive: begin
          // Supply loss wins over a simultaneous request drop and is flagged as a fault.
          if (!pwr_if.pwr_good_i) begin
            state_q <= StClamping;
            clamp_q <= 1'b1;
            ack_q   <= 1'b0;
            fault_q <= 1'b1;
          end else if (!pwr_if.pwr_req_i) begin
            state_q <= StClamping;
            clamp_q <= 1'b1;
            ack_q   <= 1'b0;
          end
        end
        StClamping: begin
          if (settle_done) begin
            state_q <= pwr_if.pwr_req_i ? StWaitPg : StOff;
          end
        end
        default: begin
          state_q <= StOff;
          clamp_q <= 1'b1;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= CLAMP_VAL;
    end else if ((state_q == StActive) && pwr_if.pwr_good_i) begin
      hold_q <= pwr_if.data_i;
    end
  end

  assign pwr_if.clamp_o   = clamp_q;
  assign pwr_if.pwr_ack_o = ack_q;
  assign pwr_if.fault_o   = fault_q;

  // ack_q is high exactly in the active state, giving a single-flop select for the pass-through.
  assign pwr_if.data_o = ack_q ? pwr_if.data_i : ((hold_q & HOLD_MASK) | (CLAMP_VAL & ~HOLD_MASK));

endmodule
